m_sr_irq_sync: RTL and testbench
================================

Name: m_sr_irq_sync

Overview:
- Downstream consumer of the NAND set/reset flag latch.
- Takes the latch's asynchronous Q output into the MasterClock domain and turns each set event into a level interrupt request with acknowledge.
- After acknowledge, drives the latch's active-low R input to clear it.
- Counts serviced events and flags re-assertion while a clear is in progress.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on Q; legal range ≥2.
- CLR_CYCLES, 2: number of MasterClock cycles ClrL is held low per clear; legal range ≥1.
- CNT_WIDTH, 4: width of the saturating event counter.

Ports:
- MasterClock  in  1  system clock; all state changes on its rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- Q  in  1  latch output; asynchronous to MasterClock; high = flag set.
- Ack  in  1  interrupt acknowledge, synchronous; sampled high for one edge.
- Irq  out  1  registered interrupt request, level.
- ClrL  out  1  registered active-low clear; connects to the latch R input.
- Overrun  out  1  sticky; latch re-found set after a clear.
- EvtCount  out  CNT_WIDTH  number of entries into REQ, saturating.

Behaviour:
- Reset (RESETL low, asynchronous):
  - Synchronizer flops and QS_d = 0.
  - Irq = 0, ClrL = 0, Overrun = 0, EvtCount = 0.
  - State = CLEAR, clear counter = CLR_CYCLES, FromAck = 0.
  - The latch is therefore cleared during reset and for CLR_CYCLES cycles after RESETL rises.
- Synchronizer: Q passes through SYNC_STAGES flops; QS is the last stage. QS_d is QS delayed one cycle. Rise = QS & ~QS_d.
- FSM states: IDLE, REQ, CLEAR, WAIT_LOW. Irq = (state==REQ). ClrL = ~(state==CLEAR). Both are registered, with no combinational path from inputs.
- IDLE:
  - Rise → REQ; EvtCount += 1, saturating at all ones.
  - Otherwise stay.
  - QS held high without a rise (e.g. after reset) is handled by WAIT_LOW, not IDLE.
- REQ:
  - Ack=1 → CLEAR; load clear counter = CLR_CYCLES; FromAck = 1.
  - Ack=0 → stay. Irq holds indefinitely.
- CLEAR:
  - Decrement counter each cycle; at 1 → WAIT_LOW with settle counter = SYNC_STAGES+1.
  - ClrL is low for exactly CLR_CYCLES cycles.
- WAIT_LOW:
  - Decrement settle counter. At expiry, decide on QS:
    - QS=0 → IDLE.
    - QS=1 → REQ; EvtCount += 1; Overrun set if FromAck=1.
  - FromAck is cleared on leaving WAIT_LOW.
- Ack outside REQ: ignored, no state or output effect.
- Ack and Rise in the same cycle: only the current state's rule applies; Rise in REQ/CLEAR is ignored, and the latch state is re-checked in WAIT_LOW.
- S and R both low at the latch (Q high during ClrL low) is tolerated; it resolves by the WAIT_LOW re-check.
- Latency:
  - Q rising (meeting setup before edge 1) → Irq high after edge SYNC_STAGES+1 (edge 3 at default).
  - Ack sampled at edge n → Irq low and ClrL low after edge n; ClrL high after edge n+CLR_CYCLES.
- Overrun and EvtCount are cleared only by reset.
- Reset mid-operation: all of the above reset values apply immediately and asynchronously, whatever the current state.

Test Plan:
- Reset then idle:
  - Stimulus: hold RESETL low 5 cycles with Q=0, release.
  - Required: ClrL=0 during reset and for 2 cycles after release; then ClrL=1, Irq=0, EvtCount=0, Overrun=0.
- Single event:
  - Stimulus: Q rises; Ack pulsed 4 cycles after Irq rises; model latch clears Q when ClrL low.
  - Required: Irq high after edge 3; Irq low and ClrL low at the Ack edge for exactly 2 cycles; EvtCount=1; Overrun=0; back in IDLE.
- Stuck source:
  - Stimulus: Q held high through the clear.
  - Required: after WAIT_LOW (3 cycles), Irq re-asserts; EvtCount=2; Overrun=1.
- Saturation:
  - Stimulus: 17 serviced events at CNT_WIDTH=4.
  - Required: EvtCount=15 and holds at 15.
- Spurious Ack:
  - Stimulus: Ack pulses in IDLE and during CLEAR.
  - Required: no change to Irq, ClrL timing, or EvtCount.
- Reset mid-request:
  - Stimulus: RESETL low while Irq=1 and Q=1, Q held high through reset.
  - Required: Irq=0 and ClrL=0 immediately; after release and WAIT_LOW, Irq=1; EvtCount=1; Overrun=0.

Source files
------------

// File: rtl/m_sr_irq_sync.sv
// m_sr_irq_sync: brings the asynchronous Q output of a NAND set/reset flag latch
// into the MasterClock domain and turns each set event into a level interrupt
// request. Once the request is acknowledged, the block pulses the latch's
// active-low R input (ClrL). It then re-checks the latch after the synchronizer
// has settled, counts serviced events and flags a source that stays set.
module m_sr_irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 MasterClock,
    input  logic                 RESETL,
    input  logic                 Q,
    input  logic                 Ack,
    output logic                 Irq,
    output logic                 ClrL,
    output logic                 Overrun,
    output logic [CNT_WIDTH-1:0] EvtCount
);

    // One down-counter serves both the clear pulse and the synchronizer settle time
    localparam int SETTLE_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_MAX       = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CW            = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        phaseCnt;
    logic                 fromAck;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                 qs;
    logic                 qsD;
    logic                 rise;

    // Saturating increment for the event counter
    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        r = v;
        if (v != {CNT_WIDTH{1'b1}}) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    assign qs   = syncQ[SYNC_STAGES-1];
    assign rise = qs & ~qsD;

    // Synchronizer chain on the asynchronous latch output plus edge-detect delay
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            syncQ <= '0;
            qsD   <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], Q};
            qsD   <= qs;
        end
    end

    // Request/clear FSM with registered Irq/ClrL and the event bookkeeping
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state    <= CLEAR;
            phaseCnt <= CLR_LOAD;
            fromAck  <= 1'b0;
            Irq      <= 1'b0;
            ClrL     <= 1'b0;
            Overrun  <= 1'b0;
            EvtCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= REQ;
                        Irq      <= 1'b1;
                        EvtCount <= satInc(EvtCount);
                    end
                end
                REQ: begin
                    if (Ack) begin
                        state    <= CLEAR;
                        phaseCnt <= CLR_LOAD;
                        fromAck  <= 1'b1;
                        Irq      <= 1'b0;
                        ClrL     <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (phaseCnt == CNT_ONE) begin
                        state    <= WAIT_LOW;
                        phaseCnt <= SETTLE_LOAD;
                        ClrL     <= 1'b1;
                    end else begin
                        phaseCnt <= phaseCnt - 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (phaseCnt == CNT_ONE) begin
                        // Latch state is now fully through the synchronizer
                        fromAck <= 1'b0;
                        if (qs) begin
                            state    <= REQ;
                            Irq      <= 1'b1;
                            EvtCount <= satInc(EvtCount);
                            if (fromAck) begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        phaseCnt <= phaseCnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Irq   <= 1'b0;
                    ClrL  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_sr_irq_sync.sv
// Directed testbench for m_sr_irq_sync. Inputs are driven and outputs sampled
// 1 time unit after each rising MasterClock edge; the latch is modelled by
// hand in the stimulus (Q dropped when a clear is issued unless held stuck).
module tb_m_sr_irq_sync;

    logic       MasterClock;
    logic       RESETL;
    logic       Q;
    logic       Ack;
    logic       Irq;
    logic       ClrL;
    logic       Overrun;
    logic [3:0] EvtCount;

    int checks   = 0;
    int failures = 0;
    int expCnt;

    m_sr_irq_sync #(
        .SYNC_STAGES(2),
        .CLR_CYCLES (2),
        .CNT_WIDTH  (4)
    ) dut (
        .MasterClock(MasterClock),
        .RESETL     (RESETL),
        .Q          (Q),
        .Ack        (Ack),
        .Irq        (Irq),
        .ClrL       (ClrL),
        .Overrun    (Overrun),
        .EvtCount   (EvtCount)
    );

    initial MasterClock = 1'b0;
    always #5 MasterClock = ~MasterClock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge MasterClock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clean event: Q rises, Irq after 3 edges, Ack, latch clears, back to IDLE
    task automatic serviceEvent(input int expAfter);
        Q = 1'b1;
        tick(2);
        check("sat_irq_early", {31'b0, Irq}, 32'd0);
        tick(1);
        check("sat_irq_up", {31'b0, Irq}, 32'd1);
        check("sat_count", {28'b0, EvtCount}, expAfter);
        Ack = 1'b1;
        tick(1);
        check("sat_clrl_low", {31'b0, ClrL}, 32'd0);
        Ack = 1'b0;
        Q   = 1'b0;
        tick(5);
        check("sat_idle_irq", {31'b0, Irq}, 32'd0);
        check("sat_idle_clrl", {31'b0, ClrL}, 32'd1);
    endtask

    initial begin
        RESETL = 1'b0;
        Q      = 1'b0;
        Ack    = 1'b0;

        // ---------------- Reset then idle ----------------
        #2;
        check("rst_clrl", {31'b0, ClrL}, 32'd0);
        check("rst_irq", {31'b0, Irq}, 32'd0);
        check("rst_cnt", {28'b0, EvtCount}, 32'd0);
        check("rst_ovr", {31'b0, Overrun}, 32'd0);
        tick(5);
        check("rst_clrl_held", {31'b0, ClrL}, 32'd0);
        RESETL = 1'b1;
        tick(1);
        check("post_rst_clrl_1", {31'b0, ClrL}, 32'd0);
        tick(1);
        check("post_rst_clrl_2", {31'b0, ClrL}, 32'd1);
        tick(3);
        check("idle_irq", {31'b0, Irq}, 32'd0);
        check("idle_cnt", {28'b0, EvtCount}, 32'd0);
        check("idle_ovr", {31'b0, Overrun}, 32'd0);
        check("idle_clrl", {31'b0, ClrL}, 32'd1);

        // ---------------- Single event ----------------
        Q = 1'b1;
        tick(1);
        check("se_irq_e1", {31'b0, Irq}, 32'd0);
        tick(1);
        check("se_irq_e2", {31'b0, Irq}, 32'd0);
        tick(1);
        check("se_irq_e3", {31'b0, Irq}, 32'd1);
        check("se_cnt", {28'b0, EvtCount}, 32'd1);
        tick(3);
        check("se_irq_hold", {31'b0, Irq}, 32'd1);
        check("se_clrl_hold", {31'b0, ClrL}, 32'd1);
        Ack = 1'b1;
        tick(1);
        check("se_ack_irq", {31'b0, Irq}, 32'd0);
        check("se_ack_clrl", {31'b0, ClrL}, 32'd0);
        Ack = 1'b0;
        Q   = 1'b0;
        tick(1);
        check("se_clrl_c2", {31'b0, ClrL}, 32'd0);
        tick(1);
        check("se_clrl_rel", {31'b0, ClrL}, 32'd1);
        tick(3);
        check("se_done_irq", {31'b0, Irq}, 32'd0);
        check("se_done_cnt", {28'b0, EvtCount}, 32'd1);
        check("se_done_ovr", {31'b0, Overrun}, 32'd0);
        tick(3);
        check("se_stay_idle", {31'b0, Irq}, 32'd0);

        // ---------------- Stuck source ----------------
        Q = 1'b1;
        tick(3);
        check("st_irq", {31'b0, Irq}, 32'd1);
        check("st_cnt1", {28'b0, EvtCount}, 32'd2);
        Ack = 1'b1;
        tick(1);
        check("st_ack_clrl", {31'b0, ClrL}, 32'd0);
        Ack = 1'b0;
        tick(2);
        check("st_clrl_rel", {31'b0, ClrL}, 32'd1);
        tick(2);
        check("st_wait_irq", {31'b0, Irq}, 32'd0);
        check("st_wait_ovr", {31'b0, Overrun}, 32'd0);
        tick(1);
        check("st_reirq", {31'b0, Irq}, 32'd1);
        check("st_cnt2", {28'b0, EvtCount}, 32'd3);
        check("st_ovr", {31'b0, Overrun}, 32'd1);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        Q   = 1'b0;
        tick(5);
        check("st_final_irq", {31'b0, Irq}, 32'd0);
        check("st_final_cnt", {28'b0, EvtCount}, 32'd3);
        check("st_ovr_sticky", {31'b0, Overrun}, 32'd1);

        // ---------------- Spurious Ack ----------------
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        check("sp_idle_irq", {31'b0, Irq}, 32'd0);
        check("sp_idle_clrl", {31'b0, ClrL}, 32'd1);
        check("sp_idle_cnt", {28'b0, EvtCount}, 32'd3);
        tick(2);
        check("sp_idle_irq2", {31'b0, Irq}, 32'd0);
        Q = 1'b1;
        tick(3);
        check("sp_irq", {31'b0, Irq}, 32'd1);
        check("sp_cnt", {28'b0, EvtCount}, 32'd4);
        Ack = 1'b1;
        tick(1);
        check("sp_clrl_c1", {31'b0, ClrL}, 32'd0);
        Q = 1'b0;
        tick(1);
        Ack = 1'b0;
        check("sp_clrl_c2", {31'b0, ClrL}, 32'd0);
        tick(1);
        check("sp_clrl_rel", {31'b0, ClrL}, 32'd1);
        check("sp_irq_low", {31'b0, Irq}, 32'd0);
        tick(3);
        check("sp_done_irq", {31'b0, Irq}, 32'd0);
        check("sp_done_cnt", {28'b0, EvtCount}, 32'd4);

        // ---------------- Saturation ----------------
        expCnt = 4;
        for (int k = 0; k < 17; k++) begin
            expCnt = (expCnt < 15) ? expCnt + 1 : 15;
            serviceEvent(expCnt);
        end
        check("sat_final", {28'b0, EvtCount}, 32'd15);
        check("sat_ovr", {31'b0, Overrun}, 32'd1);

        // ---------------- Reset mid-request ----------------
        Q = 1'b1;
        tick(3);
        check("rm_irq", {31'b0, Irq}, 32'd1);
        RESETL = 1'b0;
        #1;
        check("rm_irq_async", {31'b0, Irq}, 32'd0);
        check("rm_clrl_async", {31'b0, ClrL}, 32'd0);
        check("rm_cnt_async", {28'b0, EvtCount}, 32'd0);
        check("rm_ovr_async", {31'b0, Overrun}, 32'd0);
        tick(2);
        RESETL = 1'b1;
        tick(1);
        check("rm_clrl_1", {31'b0, ClrL}, 32'd0);
        tick(1);
        check("rm_clrl_2", {31'b0, ClrL}, 32'd1);
        tick(2);
        check("rm_wait_irq", {31'b0, Irq}, 32'd0);
        tick(1);
        check("rm_reirq", {31'b0, Irq}, 32'd1);
        check("rm_cnt", {28'b0, EvtCount}, 32'd1);
        check("rm_ovr", {31'b0, Overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
